seg7_scan_driver: RTL and testbench

- Time-multiplexed seven-segment display driver. It sits directly downstream of the generic counter.
- Consumes the counter's one-cycle trigger pulse as a digit-advance strobe. Scans NUM_DIGITS hex digits onto shared segment lines, with anti-ghosting blanking and leading-zero suppression.
- Display data is latched once per frame, so a frame never mixes old and new values.

---
 rtl/seg7_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment display driver.
// Advances one digit per STROBE_IN tick and blanks all anodes for
// BLANK_CYCLES cycles between digits to prevent ghosting. Display data is
// captured into shadow registers once per frame, at the entry of digit 0.
// Optionally suppresses leading zeros.
//
// Ports:
//   CLK            - system clock, rising edge
//   RESET          - synchronous, active-low reset
//   STROBE_IN      - one-cycle digit-advance tick
//   VALUE_IN       - hex nibbles, bits [4i+3:4i] = digit i
//   DP_IN          - per-digit decimal point request, 1 = lit
//   LZ_BLANK_IN    - 1 = suppress leading zeros
//   SEG_SELECT_OUT - active-low anode enables, at most one bit low
//   HEX_OUT        - active-low segments {dp,g,f,e,d,c,b,a}
//   FRAME_OUT      - one-cycle pulse when a new frame's data is latched
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    STROBE_IN,
  input  logic [4*NUM_DIGITS-1:0] VALUE_IN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic                    LZ_BLANK_IN,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    FRAME_OUT
);

  localparam int                IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [7:0]        BLANK_LAST = 8'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  state_t                    state_r, state_s;
  logic [IDX_W-1:0]          digit_idx_r, digit_idx_s;
  logic [7:0]                blank_cnt_r, blank_cnt_s;
  logic [4*NUM_DIGITS-1:0]   shadow_val_r, shadow_val_s;
  logic [NUM_DIGITS-1:0]     shadow_dp_r, shadow_dp_s;
  logic [NUM_DIGITS-1:0]     seg_sel_r, seg_sel_s;
  logic [7:0]                hex_r, hex_s;
  logic                      frame_r, frame_s;

  logic                      latch_s;
  logic [3:0]                digit_nib_s;
  logic                      digit_dp_s;
  logic                      digit_lz_s;

  // A frame is latched on the BLANK->SHOW transition into digit 0. The
  // digit entering SHOW is decoded from these next-shadow values so the
  // freshly latched data appears on the very first SHOW cycle.
  assign latch_s      = (state_r == ST_BLANK) && (blank_cnt_r == BLANK_LAST) &&
                        (digit_idx_r == IDX_W'(0));
  assign shadow_val_s = latch_s ? VALUE_IN : shadow_val_r;
  assign shadow_dp_s  = latch_s ? DP_IN : shadow_dp_r;

  // Select the current digit's nibble/dp and flag it as a leading zero
  // when it and every more-significant nibble are zero (digit 0 exempt).
  always_comb begin
    logic zero_above;
    zero_above  = 1'b1;
    digit_nib_s = 4'h0;
    digit_dp_s  = 1'b0;
    digit_lz_s  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (shadow_val_s[4*i +: 4] == 4'h0);
      digit_nib_s = (digit_idx_r == IDX_W'(i)) ? shadow_val_s[4*i +: 4] : digit_nib_s;
      digit_dp_s  = (digit_idx_r == IDX_W'(i)) ? shadow_dp_s[i] : digit_dp_s;
      digit_lz_s  = (digit_idx_r == IDX_W'(i)) ? (zero_above && (i != 0)) : digit_lz_s;
    end
  end

  // Next-state logic; outputs are computed from the next state so they
  // can be registered without an extra cycle of latency.
  always_comb begin
    state_s     = state_r;
    digit_idx_s = digit_idx_r;
    blank_cnt_s = blank_cnt_r;
    seg_sel_s   = {NUM_DIGITS{1'b1}};
    hex_s       = 8'hFF;
    frame_s     = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (blank_cnt_r == BLANK_LAST) begin
          state_s     = ST_SHOW;
          blank_cnt_s = 8'd0;
          frame_s     = latch_s;
          seg_sel_s   = ~(NUM_DIGITS'(1) << digit_idx_r);
          hex_s       = {~digit_dp_s,
                         (LZ_BLANK_IN && digit_lz_s) ? 7'h7F : seg7_decode(digit_nib_s)};
        end else begin
          blank_cnt_s = blank_cnt_r + 8'd1;
        end
      end
      ST_SHOW: begin
        // A strobe here is the only way out; strobes seen in BLANK are
        // simply not looked at, so they are dropped rather than queued.
        if (STROBE_IN) begin
          state_s     = ST_BLANK;
          digit_idx_s = (digit_idx_r == IDX_LAST) ? IDX_W'(0) : digit_idx_r + IDX_W'(1);
        end else begin
          seg_sel_s = seg_sel_r;
          hex_s     = hex_r;
        end
      end
      default: begin
        state_s = ST_BLANK;
      end
    endcase
  end

  // State, shadow and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r      <= ST_BLANK;
      digit_idx_r  <= IDX_W'(0);
      blank_cnt_r  <= 8'd0;
      shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      seg_sel_r    <= {NUM_DIGITS{1'b1}};
      hex_r        <= 8'hFF;
      frame_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      digit_idx_r  <= digit_idx_s;
      blank_cnt_r  <= blank_cnt_s;
      shadow_val_r <= shadow_val_s;
      shadow_dp_r  <= shadow_dp_s;
      seg_sel_r    <= seg_sel_s;
      hex_r        <= hex_s;
      frame_r      <= frame_s;
    end
  end

  assign SEG_SELECT_OUT = seg_sel_r;
  assign HEX_OUT        = hex_r;
  assign FRAME_OUT      = frame_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (NUM_DIGITS=4, BLANK_CYCLES=2).
// Stimulus pushes the expected anode/segment/frame values and the cycle at
// which each digit should appear; a monitor pops an entry whenever the
// anodes leave the all-off state.
module tb_seg7_scan_driver;

  logic        CLK;
  logic        RESET;
  logic        STROBE_IN;
  logic [15:0] VALUE_IN;
  logic [3:0]  DP_IN;
  logic        LZ_BLANK_IN;
  logic [3:0]  SEG_SELECT_OUT;
  logic [7:0]  HEX_OUT;
  logic        FRAME_OUT;

  typedef struct {
    logic [3:0] seg;
    logic [7:0] hex;
    logic       frame;
    int         due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .BLANK_CYCLES(2)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STROBE_IN     (STROBE_IN),
    .VALUE_IN      (VALUE_IN),
    .DP_IN         (DP_IN),
    .LZ_BLANK_IN   (LZ_BLANK_IN),
    .SEG_SELECT_OUT(SEG_SELECT_OUT),
    .HEX_OUT       (HEX_OUT),
    .FRAME_OUT     (FRAME_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a digit entry is the first cycle with an anode enabled.
  initial begin
    logic [3:0] prev_seg;
    exp_t       e;
    prev_seg = 4'hF;
    forever begin
      @(negedge CLK);
      if (!$isunknown(SEG_SELECT_OUT)) begin
        if (prev_seg == 4'hF && SEG_SELECT_OUT != 4'hF) begin
          if (q.size() == 0) begin
            chk("unexpected_show", {28'd0, SEG_SELECT_OUT}, 32'hF);
          end else begin
            e = q.pop_front();
            chk("anode", {28'd0, SEG_SELECT_OUT}, {28'd0, e.seg});
            chk("hex", {24'd0, HEX_OUT}, {24'd0, e.hex});
            chk("frame", {31'd0, FRAME_OUT}, {31'd0, e.frame});
            chk("show_latency", cyc, e.due);
          end
        end else if (FRAME_OUT === 1'b1) begin
          chk("stray_frame", {31'd0, FRAME_OUT}, 32'd0);
        end
        prev_seg = SEG_SELECT_OUT;
      end
    end
  end

  // Single-cycle strobe from SHOW; next digit shows BLANK_CYCLES+1 later.
  task automatic strobe1(input logic [3:0] s, input logic [7:0] h, input logic f);
    @(negedge CLK);
    STROBE_IN = 1'b1;
    q.push_back('{seg: s, hex: h, frame: f, due: cyc + 3});
    @(negedge CLK);
    STROBE_IN = 1'b0;
    repeat (7) @(negedge CLK);
  endtask

  // One-cycle reset; checks reset outputs and expects a restart at digit 0.
  task automatic do_reset(input logic [7:0] h0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_anode", {28'd0, SEG_SELECT_OUT}, 32'hF);
    chk("rst_hex", {24'd0, HEX_OUT}, 32'hFF);
    chk("rst_frame", {31'd0, FRAME_OUT}, 32'd0);
    q.push_back('{seg: 4'hE, hex: h0, frame: 1'b1, due: cyc + 2});
    RESET = 1'b1;
  endtask

  initial begin
    RESET       = 1'b0;
    STROBE_IN   = 1'b0;
    VALUE_IN    = 16'h1234;
    DP_IN       = 4'b0000;
    LZ_BLANK_IN = 1'b0;

    // Power-up reset, then digit "4" held with no strobes.
    do_reset(8'h99);
    repeat (12) @(negedge CLK);
    chk("hold_anode", {28'd0, SEG_SELECT_OUT}, 32'hE);
    chk("hold_hex", {24'd0, HEX_OUT}, 32'h99);

    // DP change is not visible until the next digit-0 latch.
    DP_IN = 4'b0100;
    strobe1(4'hD, 8'hB0, 1'b0);
    strobe1(4'hB, 8'hA4, 1'b0);
    strobe1(4'h7, 8'hF9, 1'b0);
    strobe1(4'hE, 8'h99, 1'b1);
    strobe1(4'hD, 8'hB0, 1'b0);
    strobe1(4'hB, 8'h24, 1'b0);

    // New value mid-frame: digit 3 still shows old data.
    VALUE_IN = 16'hABCD;
    DP_IN    = 4'b0000;
    strobe1(4'h7, 8'hF9, 1'b0);
    strobe1(4'hE, 8'hA1, 1'b1);
    strobe1(4'hD, 8'hC6, 1'b0);
    strobe1(4'hB, 8'h83, 1'b0);
    strobe1(4'h7, 8'h88, 1'b0);

    // Leading-zero suppression.
    LZ_BLANK_IN = 1'b1;
    VALUE_IN    = 16'h0050;
    strobe1(4'hE, 8'hC0, 1'b1);
    strobe1(4'hD, 8'h92, 1'b0);
    strobe1(4'hB, 8'hFF, 1'b0);
    strobe1(4'h7, 8'hFF, 1'b0);

    VALUE_IN = 16'h0000;
    DP_IN    = 4'b1000;
    strobe1(4'hE, 8'hC0, 1'b1);
    strobe1(4'hD, 8'hFF, 1'b0);
    strobe1(4'hB, 8'hFF, 1'b0);
    strobe1(4'h7, 8'h7F, 1'b0);

    // Strobe pulse during BLANK is dropped.
    @(negedge CLK);
    STROBE_IN = 1'b1;
    q.push_back('{seg: 4'hE, hex: 8'hC0, frame: 1'b1, due: cyc + 3});
    @(negedge CLK);
    STROBE_IN = 1'b0;
    @(negedge CLK);
    STROBE_IN = 1'b1;
    @(negedge CLK);
    STROBE_IN = 1'b0;
    repeat (10) @(negedge CLK);
    chk("blank_strobe_anode", {28'd0, SEG_SELECT_OUT}, 32'hE);

    // Strobe held 5 cycles: one advance per SHOW entry (d1 then d2).
    LZ_BLANK_IN = 1'b0;
    VALUE_IN    = 16'h1234;
    DP_IN       = 4'b0000;
    @(negedge CLK);
    STROBE_IN = 1'b1;
    q.push_back('{seg: 4'hD, hex: 8'hC0, frame: 1'b0, due: cyc + 3});
    q.push_back('{seg: 4'hB, hex: 8'hC0, frame: 1'b0, due: cyc + 6});
    repeat (5) @(negedge CLK);
    STROBE_IN = 1'b0;
    repeat (8) @(negedge CLK);
    chk("held_strobe_anode", {28'd0, SEG_SELECT_OUT}, 32'hB);

    // Reset while digit 2 is shown: restart at digit 0 with fresh data.
    do_reset(8'h99);
    repeat (6) @(negedge CLK);
    strobe1(4'hD, 8'hB0, 1'b0);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge CLK);
    chk("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
